// File: rtl/regfile_mp_sb_pkg.sv
// rtl/regfile_mp_sb_pkg.sv - shared widths, reset/enable levels and helpers for the register file
// Purpose: single home for the register-file geometry and control encodings.
// Contents: XLEN, NREGS, AW, ZeroReg, ZeroRegAddr, RstEnable, WriteEnable,
//           ReadEnable, and an address range helper.
package regfile_mp_sb_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  localparam logic [XLEN-1:0] ZeroReg     = '0;
  localparam logic [AW-1:0]   ZeroRegAddr = '0;
  localparam logic            RstEnable   = 1'b1;
  localparam logic            WriteEnable = 1'b1;
  localparam logic            ReadEnable  = 1'b1;

  // Only matters when NREGS is not a power of two; otherwise always true.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return (32'(addr) < 32'(NREGS));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: write bypass mux plus busy qualification
// Purpose: resolves one combinational read against the stored value and the
//          write ports active this cycle, and qualifies the scoreboard bit.
// Ports:
//   rst        in   reset level (forces data/busy to zero while asserted)
//   addr       in   read address
//   en         in   read enable
//   in_range   in   addr is a valid register index
//   reg_data   in   stored value of regs[addr]
//   reg_busy   in   scoreboard bit of regs[addr]
//   wen        in   write enables of all write ports
//   wr_addr    in   write addresses, port j = [j*AW +: AW]
//   wr_data    in   write data, port j = [j*XLEN +: XLEN]
//   data       out  resolved read data
//   busy       out  pending writer not satisfied by a bypass this cycle
module regfile_rd_port
  import regfile_mp_sb_pkg::*;
#(
  parameter int NWR = 2
) (
  input  logic                rst,
  input  logic [AW-1:0]       addr,
  input  logic                en,
  input  logic                in_range,
  input  logic [XLEN-1:0]     reg_data,
  input  logic                reg_busy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     data,
  output logic                busy
);

  logic            hit;
  logic [XLEN-1:0] byp_data;

  // Ascending scan so the highest matching write port ends up selected.
  always_comb begin
    hit      = 1'b0;
    byp_data = ZeroReg;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] == WriteEnable && wr_addr[j*AW +: AW] == addr) begin
        hit      = 1'b1;
        byp_data = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    data = ZeroReg;
    busy = 1'b0;
    if (rst != RstEnable && en == ReadEnable && addr != ZeroRegAddr && in_range) begin
      if (hit) begin
        data = byp_data;
      end else begin
        data = reg_data;
        busy = reg_busy;
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port integer register file with bypass and busy scoreboard
// Purpose: NRD combinational read ports, NWR registered write ports (higher
//          index wins), same-cycle write-to-read bypass and a per-register
//          pending-writer scoreboard; x0 reads zero and is never busy.
// Ports:
//   clk          in   clock
//   rstn         in   synchronous reset, active high
//   rd_addr_i    in   read addresses, port k = [k*AW +: AW]
//   rd_en_i      in   read enables
//   rd_data_o    out  read data, port k = [k*XLEN +: XLEN]
//   rd_busy_o    out  read register has an un-bypassed pending writer
//   wen_i        in   write enables
//   wr_addr_i    in   write addresses
//   wr_data_i    in   write data
//   iss_valid_i  in   an instruction with a destination issues
//   iss_rd_i     in   destination of the issuing instruction
//   flush_i      in   clears every busy bit
//   busy_vec_o   out  registered scoreboard state
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  input  logic [NRD-1:0]      rd_en_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wen_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                flush_i,
  output logic [NREGS-1:0]    busy_vec_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Storage: later ports in the loop overwrite earlier ones on a collision.
  always_ff @(posedge clk) begin
    if (rstn == RstEnable) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= ZeroReg;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j] == WriteEnable &&
            wr_addr_i[j*AW +: AW] != ZeroRegAddr &&
            addr_in_range(wr_addr_i[j*AW +: AW])) begin
          regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Scoreboard: flush beats issue, issue beats a same-cycle writeback clear.
  always_comb begin
    busy_next = busy;
    busy_next[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      logic clr;
      clr = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j] == WriteEnable && wr_addr_i[j*AW +: AW] == AW'(r)) begin
          clr = 1'b1;
        end
      end
      if (flush_i) begin
        busy_next[r] = 1'b0;
      end else if (iss_valid_i && iss_rd_i == AW'(r)) begin
        busy_next[r] = 1'b1;
      end else if (clr) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn == RstEnable) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_vec_o = busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            in_range;
    logic [XLEN-1:0] reg_data;
    logic            reg_busy;

    assign addr     = rd_addr_i[k*AW +: AW];
    assign in_range = addr_in_range(addr);
    assign reg_data = in_range ? regs[addr] : ZeroReg;
    assign reg_busy = in_range ? busy[addr] : 1'b0;

    regfile_rd_port #(
      .NWR (NWR)
    ) u_rd_port (
      .rst      (rstn),
      .addr     (addr),
      .en       (rd_en_i[k]),
      .in_range (in_range),
      .reg_data (reg_data),
      .reg_busy (reg_busy),
      .wen      (wen_i),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .data     (rd_data_o[k*XLEN +: XLEN]),
      .busy     (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk;
  logic                rstn;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD-1:0]      rd_en_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wen_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                iss_valid_i;
  logic [AW-1:0]       iss_rd_i;
  logic                flush_i;
  logic [NREGS-1:0]    busy_vec_o;

  int errors = 0;
  int checks = 0;

  regfile_mp_sb #(.NRD(NRD), .NWR(NWR)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rd_addr_i   (rd_addr_i),
    .rd_en_i     (rd_en_i),
    .rd_data_o   (rd_data_o),
    .rd_busy_o   (rd_busy_o),
    .wen_i       (wen_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .flush_i     (flush_i),
    .busy_vec_o  (busy_vec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a, input logic en);
    rd_addr_i[k*AW +: AW] = a;
    rd_en_i[k] = en;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wen_i[j] = en;
    wr_addr_i[j*AW +: AW] = a;
    wr_data_i[j*XLEN +: XLEN] = d;
  endtask

  function automatic logic [XLEN-1:0] rdata(input int k);
    return rd_data_o[k*XLEN +: XLEN];
  endfunction

  task automatic idle();
    wen_i = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    iss_valid_i = 1'b0;
    iss_rd_i = '0;
    flush_i = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    rd_addr_i = '0;
    rd_en_i = '0;
    idle();
    tick();
    tick();

    // Combinational override while reset is held.
    set_rd(0, 5'd5, 1'b1);
    set_rd(1, 5'd31, 1'b1);
    set_wr(0, 1'b1, 5'd5, 32'hCAFE_0001);
    settle();
    check("rst_override_data0", rdata(0), 0);
    check("rst_override_busy", rd_busy_o, 0);
    idle();
    tick();
    rstn = 1'b0;

    // 1: every register on every port reads zero, not busy.
    for (int r = 0; r < NREGS; r++) begin
      set_rd(0, AW'(r), 1'b1);
      set_rd(1, AW'(r), 1'b1);
      settle();
      check($sformatf("reset_p0_x%0d", r), rdata(0), 0);
      check($sformatf("reset_p1_x%0d", r), rdata(1), 0);
      check($sformatf("reset_busy_x%0d", r), rd_busy_o, 0);
    end
    check("reset_busy_vec", busy_vec_o, 0);

    // 2: single write then read on both ports; x0 write discarded.
    tick();
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    set_rd(0, 5'd5, 1'b1);
    set_rd(1, 5'd5, 1'b1);
    settle();
    check("x5_p0", rdata(0), 32'hDEAD_BEEF);
    check("x5_p1", rdata(1), 32'hDEAD_BEEF);
    set_rd(1, 5'd5, 1'b0);
    settle();
    check("x5_p1_disabled", rdata(1), 0);
    set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(1, 5'd0, 1'b1);
    settle();
    check("x0_bypass_zero", rdata(1), 0);
    tick();
    idle();
    settle();
    check("x0_after_write", rdata(1), 0);

    // 3: colliding writes, higher port wins in bypass and in storage.
    set_wr(0, 1'b1, 5'd7, 32'h11);
    set_wr(1, 1'b1, 5'd7, 32'h22);
    set_rd(0, 5'd7, 1'b1);
    set_rd(1, 5'd7, 1'b1);
    settle();
    check("x7_bypass_p0", rdata(0), 32'h22);
    check("x7_bypass_p1", rdata(1), 32'h22);
    tick();
    idle();
    settle();
    check("x7_stored", rdata(0), 32'h22);

    // 4: issue sets busy; writeback bypasses and clears it.
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd9;
    set_rd(0, 5'd9, 1'b1);
    settle();
    check("x9_busy_same_cycle_issue", rd_busy_o[0], 1'b0);
    tick();
    idle();
    settle();
    check("x9_busy", rd_busy_o[0], 1'b1);
    check("x9_busy_vec", busy_vec_o[9], 1'b1);
    set_wr(0, 1'b1, 5'd9, 32'h55);
    settle();
    check("x9_bypass_data", rdata(0), 32'h55);
    check("x9_bypass_busy", rd_busy_o[0], 1'b0);
    tick();
    idle();
    settle();
    check("x9_cleared_vec", busy_vec_o[9], 1'b0);
    check("x9_stored", rdata(0), 32'h55);
    check("x9_not_busy", rd_busy_o[0], 1'b0);

    // Issue to x0 is ignored.
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd0;
    tick();
    idle();
    settle();
    check("x0_never_busy", busy_vec_o, 0);

    // 5: issue wins over same-cycle clear; flush clears everything.
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd3;
    set_wr(0, 1'b1, 5'd3, 32'h33);
    tick();
    idle();
    settle();
    check("x3_set_wins", busy_vec_o[3], 1'b1);
    set_rd(1, 5'd3, 1'b1);
    settle();
    check("x3_rd_busy_p1", rd_busy_o[1], 1'b1);
    check("x3_data", rdata(1), 32'h33);
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd4;
    tick();
    iss_rd_i = 5'd6;
    tick();
    idle();
    settle();
    check("busy_vec_3_4_6", busy_vec_o, 32'h0000_0058);
    flush_i = 1'b1;
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd10;
    tick();
    idle();
    settle();
    check("flush_clears", busy_vec_o, 0);

    // 6: mid-run reset with write and issue in flight.
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd13;
    tick();
    set_wr(0, 1'b1, 5'd12, 32'hAB);
    set_wr(1, 1'b1, 5'd14, 32'hCD);
    iss_valid_i = 1'b1;
    iss_rd_i = 5'd15;
    rstn = 1'b1;
    set_rd(0, 5'd5, 1'b1);
    set_rd(1, 5'd13, 1'b1);
    settle();
    check("midrst_override_data", rdata(0), 0);
    check("midrst_override_busy", rd_busy_o, 0);
    tick();
    rstn = 1'b0;
    idle();
    settle();
    check("midrst_x5", rdata(0), 0);
    check("midrst_busy_vec", busy_vec_o, 0);
    set_rd(0, 5'd12, 1'b1);
    set_rd(1, 5'd14, 1'b1);
    settle();
    check("midrst_x12_not_committed", rdata(0), 0);
    check("midrst_x14_not_committed", rdata(1), 0);
    set_rd(0, 5'd7, 1'b1);
    set_rd(1, 5'd9, 1'b1);
    settle();
    check("midrst_x7", rdata(0), 0);
    check("midrst_x9", rdata(1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
